// File: rtl/bus_pkg.sv
// Shared definitions for the SoC data-bus slave responders: bus widths,
// responder FSM states and the address-window mask helper.
package bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    WAIT,
    RESP
  } bus_resp_state_e;

  // Low-order address bits that index inside a 2**aw byte window.
  function automatic logic [BUS_ADDR_W-1:0] window_mask(int unsigned aw);
    return BUS_ADDR_W'((64'd1 << aw) - 64'd1);
  endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// req/gnt/rvalid data-bus port; the master drives requests, the slave
// answers with grant and a single-cycle response.
interface bus_mem_responder_if;
  import bus_pkg::*;

  logic                  req;
  logic [BUS_ADDR_W-1:0] addr;
  logic                  we;
  logic [BUS_BE_W-1:0]   be;
  logic [BUS_DATA_W-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [BUS_DATA_W-1:0] rdata;
  logic                  err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/bus_mem_responder_delay.sv
// Response delay down-counter: loaded with LATENCY at grant, decremented
// while waiting; done flags that the next cycle is the response cycle.
module resp_delay_counter #(
  parameter int unsigned LATENCY = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LATENCY);
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count <= CNT_W'(1));

endmodule

// File: rtl/bus_mem_responder.sv
// Single-window memory slave: decodes the window, drives a 1-cycle SRAM/ROM
// and returns one response LATENCY cycles after the inherent read cycle.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [BUS_ADDR_W-1:0] BASE_ADDR = 32'h1C000000,
  parameter int unsigned LATENCY = 7,
  parameter bit READ_ONLY = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bus_mem_responder_if.slave    bus,
  output logic                  mem_en_o,
  output logic [BUS_BE_W-1:0]   mem_we_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic [BUS_DATA_W-1:0] mem_wdata_o,
  input  logic [BUS_DATA_W-1:0] mem_rdata_i
);

  localparam logic [BUS_ADDR_W-1:0] WIN_MASK = window_mask(ADDR_WIDTH);

  bus_resp_state_e state, state_n;

  logic                  hit, bad;
  logic                  grant, count_dec, delay_done;
  logic                  we_q, bad_q;
  logic [BUS_DATA_W-1:0] hold;
  logic                  rd_ok;

  assign hit   = (bus.addr & ~WIN_MASK) == BASE_ADDR;
  assign bad   = !hit || (READ_ONLY && bus.we);
  assign rd_ok = !we_q && !bad_q;

  resp_delay_counter #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .load (grant),
    .dec  (count_dec),
    .done (delay_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: the hold register is reset for clean idle outputs; the SRAM array
  // itself is never reset, so a write strobed before reset stays written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      bad_q <= 1'b0;
      hold  <= '0;
    end else begin
      if (grant) begin
        we_q  <= bus.we;
        bad_q <= bad;
      end
      if (state == CAPT) hold <= mem_rdata_i;
    end
  end

  // NOTE: every output and next-state is defaulted first so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    grant       = 1'b0;
    count_dec   = 1'b0;
    bus.gnt     = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.err     = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state)
      IDLE: begin
        if (bus.req) begin
          grant       = 1'b1;
          bus.gnt     = 1'b1;
          mem_en_o    = !bad;
          mem_we_o    = (bus.we && !bad) ? bus.be : '0;
          mem_addr_o  = bus.addr[ADDR_WIDTH-1:2];
          mem_wdata_o = bus.wdata;
          state_n     = CAPT;
        end
      end
      CAPT: begin
        if (LATENCY == 0) begin
          // Zero extra latency: the SRAM output is returned as it arrives.
          bus.rvalid = 1'b1;
          bus.err    = bad_q;
          bus.rdata  = rd_ok ? mem_rdata_i : '0;
          state_n    = IDLE;
        end else begin
          count_dec = 1'b1;
          state_n   = delay_done ? RESP : WAIT;
        end
      end
      WAIT: begin
        count_dec = 1'b1;
        if (delay_done) state_n = RESP;
      end
      RESP: begin
        bus.rvalid = 1'b1;
        bus.err    = bad_q;
        bus.rdata  = rd_ok ? hold : '0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: a latency-7 RAM, a latency-3 boot
// ROM and a latency-0 RAM, each backed by a behavioural 1-cycle SRAM.
module tb_bus_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q_ram[$];
  exp_t q_rom[$];
  exp_t q_fast[$];

  bus_mem_responder_if ram_if ();
  bus_mem_responder_if rom_if ();
  bus_mem_responder_if fast_if ();

  logic        ram_en,  rom_en,  fast_en;
  logic [3:0]  ram_we,  rom_we,  fast_we;
  logic [13:0] ram_addr, rom_addr;
  logic [9:0]  fast_addr;
  logic [31:0] ram_wd,  rom_wd,  fast_wd;
  logic [31:0] ram_rd = '0, rom_rd = '0, fast_rd = '0;

  bus_mem_responder #(.ADDR_WIDTH(16), .BASE_ADDR(32'h1C000000), .LATENCY(7), .READ_ONLY(1'b0)) u_ram (
    .clk(clk), .rst_n(rst_n), .bus(ram_if),
    .mem_en_o(ram_en), .mem_we_o(ram_we), .mem_addr_o(ram_addr),
    .mem_wdata_o(ram_wd), .mem_rdata_i(ram_rd)
  );

  bus_mem_responder #(.ADDR_WIDTH(16), .BASE_ADDR(32'h1A000000), .LATENCY(3), .READ_ONLY(1'b1)) u_rom (
    .clk(clk), .rst_n(rst_n), .bus(rom_if),
    .mem_en_o(rom_en), .mem_we_o(rom_we), .mem_addr_o(rom_addr),
    .mem_wdata_o(rom_wd), .mem_rdata_i(rom_rd)
  );

  bus_mem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h1C000000), .LATENCY(0), .READ_ONLY(1'b0)) u_fast (
    .clk(clk), .rst_n(rst_n), .bus(fast_if),
    .mem_en_o(fast_en), .mem_we_o(fast_we), .mem_addr_o(fast_addr),
    .mem_wdata_o(fast_wd), .mem_rdata_i(fast_rd)
  );

  // Behavioural SRAMs: 1-cycle read, byte-strobed write, preloaded once.
  logic [31:0] ram_mem  [16384];
  logic [31:0] rom_mem  [16384];
  logic [31:0] fast_mem [1024];
  bit loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16384; i++) begin
        ram_mem[i] <= '0;
        rom_mem[i] <= '0;
      end
      for (int i = 0; i < 1024; i++) fast_mem[i] <= '0;
      ram_mem[4]  <= 32'hDEADBEEF;
      ram_mem[8]  <= 32'hAABBCCDD;
      rom_mem[0]  <= 32'hB007C0DE;
      fast_mem[1] <= 32'h12345678;
      fast_mem[2] <= 32'h9ABCDEF0;
      fast_mem[3] <= 32'h0BADF00D;
      loaded      <= 1'b1;
    end else begin
      if (ram_en) begin
        for (int b = 0; b < 4; b++) if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
        ram_rd <= ram_mem[ram_addr];
      end
      if (rom_en) begin
        for (int b = 0; b < 4; b++) if (rom_we[b]) rom_mem[rom_addr][8*b +: 8] <= rom_wd[8*b +: 8];
        rom_rd <= rom_mem[rom_addr];
      end
      if (fast_en) begin
        for (int b = 0; b < 4; b++) if (fast_we[b]) fast_mem[fast_addr][8*b +: 8] <= fast_wd[8*b +: 8];
        fast_rd <= fast_mem[fast_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int sel);
    case (sel)
      0:       return 7;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_ram.size();
      1:       return q_rom.size();
      default: return q_fast.size();
    endcase
  endfunction

  task automatic drive(input int sel, input logic req, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    case (sel)
      0: begin ram_if.req = req;  ram_if.addr = addr;  ram_if.we = we;  ram_if.be = be;  ram_if.wdata = wd;  end
      1: begin rom_if.req = req;  rom_if.addr = addr;  rom_if.we = we;  rom_if.be = be;  rom_if.wdata = wd;  end
      default: begin fast_if.req = req; fast_if.addr = addr; fast_if.we = we; fast_if.be = be; fast_if.wdata = wd; end
    endcase
  endtask

  task automatic sample_grant(input int sel, output logic g, output logic en, output logic [3:0] mwe,
                              output logic [31:0] ma, output logic [31:0] mwd);
    case (sel)
      0: begin g = ram_if.gnt;  en = ram_en;  mwe = ram_we;  ma = 32'(ram_addr);  mwd = ram_wd;  end
      1: begin g = rom_if.gnt;  en = rom_en;  mwe = rom_we;  ma = 32'(rom_addr);  mwd = rom_wd;  end
      default: begin g = fast_if.gnt; en = fast_en; mwe = fast_we; ma = 32'(fast_addr); mwd = fast_wd; end
    endcase
  endtask

  task automatic push_exp(input int sel, input exp_t e);
    case (sel)
      0:       q_ram.push_back(e);
      1:       q_rom.push_back(e);
      default: q_fast.push_back(e);
    endcase
  endtask

  // Issue one request, check the grant-cycle SRAM drive, queue the response.
  task automatic issue(input int sel, input string tag, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_maddr,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit track, input bit hold, output int gcyc, output int waited);
    logic g, en;
    logic [3:0] mwe;
    logic [31:0] ma, mwd;
    int start;
    exp_t e;
    gcyc = -1;
    waited = 0;
    @(negedge clk);
    drive(sel, 1'b1, addr, we, be, wd);
    #1;
    start = cyc;
    for (int i = 0; i < 40; i++) begin
      sample_grant(sel, g, en, mwe, ma, mwd);
      if (g) begin
        gcyc = cyc;
        break;
      end
      @(negedge clk);
      #1;
    end
    checks++;
    if (gcyc < 0) begin
      errors++;
      $display("FAIL %s_gnt: no gnt within 40 cycles, expected a grant", tag);
      drive(sel, 1'b0, '0, 1'b0, '0, '0);
      return;
    end
    waited = gcyc - start;
    check({tag, "_mem_en"}, 32'(en), 32'(exp_en));
    check({tag, "_mem_we"}, 32'(mwe), 32'(exp_we));
    check({tag, "_mem_addr"}, ma, exp_maddr);
    check({tag, "_mem_wdata"}, mwd, wd);
    if (track) begin
      e.tag = tag;
      e.rdata = exp_rdata;
      e.err = exp_err;
      e.due = gcyc + 1 + lat_of(sel);
      push_exp(sel, e);
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      drive(sel, 1'b0, '0, 1'b0, '0, '0);
    end
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 300; i++) begin
      if (qsize(sel) == 0) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL drain_dut%0d: %0d responses still pending, expected 0", sel, qsize(sel));
  endtask

  // Monitor: pops the scoreboard on every rvalid, checks idle outputs otherwise.
  task automatic mon(input int sel, input logic rv, input logic [31:0] rd, input logic er);
    exp_t e;
    bit have;
    if (rv) begin
      have = 1'b0;
      case (sel)
        0:       if (q_ram.size()  > 0) begin e = q_ram.pop_front();  have = 1'b1; end
        1:       if (q_rom.size()  > 0) begin e = q_rom.pop_front();  have = 1'b1; end
        default: if (q_fast.size() > 0) begin e = q_fast.pop_front(); have = 1'b1; end
      endcase
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_rvalid_dut%0d: rvalid=1 at cycle %0d, expected no response", sel, cyc);
      end else begin
        check({e.tag, "_rdata"}, rd, e.rdata);
        check({e.tag, "_err"}, 32'(er), 32'(e.err));
        check({e.tag, "_rvalid_cycle"}, 32'(cyc), 32'(e.due));
      end
    end else begin
      check($sformatf("idle_rdata_dut%0d", sel), rd, '0);
      check($sformatf("idle_err_dut%0d", sel), 32'(er), '0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ram_if.rvalid,  ram_if.rdata,  ram_if.err);
      mon(1, rom_if.rvalid,  rom_if.rdata,  rom_if.err);
      mon(2, fast_if.rvalid, fast_if.rdata, fast_if.err);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1, g2, w;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Reset state: all idle outputs low.
    check("rst_ram_gnt",    32'(ram_if.gnt),    '0);
    check("rst_ram_rvalid", 32'(ram_if.rvalid), '0);
    check("rst_ram_mem_en", 32'(ram_en),        '0);
    check("rst_ram_mem_we", 32'(ram_we),        '0);
    check("rst_rom_rvalid", 32'(rom_if.rvalid), '0);
    check("rst_fast_rvalid", 32'(fast_if.rvalid), '0);
    mon_en = 1'b1;

    // RAM, latency 7.
    issue(0, "ram_rd4", 32'h1C000010, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, g1, w);
    drain(0);
    issue(0, "ram_wr8", 32'h1C000020, 1'b1, 4'b0101, 32'h11223344, 1'b1, 4'b0101, 32'd8, 32'h0, 1'b0, 1'b1, 1'b0, g1, w);
    drain(0);
    issue(0, "ram_rb8", 32'h1C000020, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd8, 32'hAA22CC44, 1'b0, 1'b1, 1'b0, g1, w);
    drain(0);
    issue(0, "ram_oow", 32'h1D000000, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 1'b1, 1'b0, g1, w);
    drain(0);
    // Request held through the busy period: next grant LATENCY+2 later.
    issue(0, "ram_held_a", 32'h1C000010, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, g1, w);
    issue(0, "ram_held_b", 32'h1C000020, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd8, 32'hAA22CC44, 1'b0, 1'b1, 1'b0, g2, w);
    check("ram_held_gnt_spacing", 32'(g2 - g1), 32'd9);
    drain(0);

    // Boot ROM, latency 3, read-only.
    issue(1, "rom_wr", 32'h1A000000, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 1'b1, 1'b0, g1, w);
    drain(1);
    issue(1, "rom_rd", 32'h1A000000, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd0, 32'hB007C0DE, 1'b0, 1'b1, 1'b0, g1, w);
    drain(1);

    // Zero-latency RAM: back-to-back reads with req held high.
    issue(2, "fast_a", 32'h1C000004, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd1, 32'h12345678, 1'b0, 1'b1, 1'b1, g1, w);
    issue(2, "fast_b", 32'h1C000008, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd2, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0, g2, w);
    check("fast_gnt_spacing", 32'(g2 - g1), 32'd2);
    drain(2);
    issue(2, "fast_be0", 32'h1C00000C, 1'b1, 4'h0, 32'hCAFEF00D, 1'b1, 4'h0, 32'd3, 32'h0, 1'b0, 1'b1, 1'b0, g1, w);
    drain(2);
    issue(2, "fast_be0_rb", 32'h1C00000C, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd3, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, g1, w);
    drain(2);
    issue(2, "fast_oow", 32'h1C001000, 1'b1, 4'hF, 32'h55AA55AA, 1'b0, 4'h0, 32'd0, 32'h0, 1'b1, 1'b1, 1'b0, g1, w);
    drain(2);

    // Reset during a latency-7 read: the response must never appear.
    issue(0, "ram_drop", 32'h1C000010, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, g1, w);
    while (cyc < g1 + 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("post_rst_gnt",    32'(ram_if.gnt),    '0);
    check("post_rst_rvalid", 32'(ram_if.rvalid), '0);
    check("post_rst_mem_en", 32'(ram_en),        '0);
    issue(0, "ram_after_rst", 32'h1C000010, 1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'd4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, g1, w);
    check("after_rst_gnt_wait", 32'(w), 32'd0);
    drain(0);

    repeat (3) @(negedge clk);
    check("end_q_ram",  32'(q_ram.size()),  '0);
    check("end_q_rom",  32'(q_rom.size()),  '0);
    check("end_q_fast", 32'(q_fast.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
